fpu_program_sequencer: RTL
==========================

Name: fpu_program_sequencer

Overview:
Controller that runs a stored FPU program without testbench involvement. It fetches 16-bit instructions from instruction memory and reads the 128-bit operand pair from data memory. It issues each operation to the FPU over a req/ack handshake and writes the 64-bit result into a result buffer. It sits between the program counter/instruction memory/data memory and the FPU, and replaces the free-running program counter when programs are launched by software.

Parameters:
PC_WIDTH, 8, instruction address width; also the width of prog_len and res_wr_addr
ADDR_WIDTH, 13, data memory address width (instruction bits [15:3])
DATA_WIDTH, 64, FPU operand/result width (IEEE-754 double)
FPU_TIMEOUT, 64, maximum cycles to wait for fpu_ack; must be >= 1

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  one-cycle pulse; launches a program at PC 0; ignored while busy
prog_len  input  PC_WIDTH  number of instructions to run; sampled when start is accepted
imem_addr  output  PC_WIDTH  instruction address (current PC)
imem_instr  input  16  instruction; combinational from imem_addr
dmem_addr  output  ADDR_WIDTH  operand-pair address
dmem_rd_en  output  1  data memory read strobe; data is valid 1 cycle later
dmem_data  input  2*DATA_WIDTH  [127:64] = operand A, [63:0] = operand B
fpu_a, fpu_b  output  DATA_WIDTH  FPU operands; registered, stable while fpu_req is high
fpu_op  output  2  00 ADD, 01 SUB, 10 MUL, 11 DIV
fpu_req  output  1  operation request
fpu_ack  input  1  FPU result valid; may assert in the same cycle as fpu_req
fpu_result  input  DATA_WIDTH  sampled when fpu_req && fpu_ack
res_wr_en  output  1  result write strobe, one cycle
res_wr_addr  output  PC_WIDTH  result index = PC of the instruction
res_wr_data  output  DATA_WIDTH  captured FPU result
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle pulse at program end (normal, halt, or abort)
err_timeout  output  1  sticky FPU timeout flag; cleared on the next accepted start

Behaviour:
- Instruction decode: [15:3] data address; [2] HALT (stop after this instruction); [1:0] opcode.
- Reset (async): state IDLE; PC=0; all outputs 0 (including fpu_a/b/op, res_wr_*, err_timeout). fpu_req drops immediately, even mid-handshake. No write completes for an interrupted instruction.
- State machine:
  - IDLE: on start, latch prog_len and clear err_timeout. If prog_len==0 go to DONE, else go to FETCH with PC=0.
  - FETCH (1 cycle): imem_addr=PC; register the instruction; go to READ.
  - READ (1 cycle): dmem_addr=instr[15:3]; dmem_rd_en=1; go to WAIT_DATA.
  - WAIT_DATA (1 cycle): register dmem_data into fpu_a/fpu_b and instr[1:0] into fpu_op; go to EXEC.
  - EXEC: fpu_req=1. When fpu_ack is seen, capture fpu_result, drop fpu_req the next cycle, and go to WRITE.
    - Cycle counter starts at 1 on EXEC entry.
    - If the counter reaches FPU_TIMEOUT with no ack, set err_timeout and go to DONE; no write for that instruction.
  - WRITE (1 cycle): res_wr_en=1, res_wr_addr=PC, res_wr_data=captured result.
    - If HALT, or PC==prog_len-1, go to DONE.
    - Otherwise PC<=PC+1 and go to FETCH.
  - DONE (1 cycle): done=1; busy=0; go to IDLE.
- Latency: with ack in the first EXEC cycle, each instruction takes 5 cycles (FETCH..WRITE). A program of N instructions gives done 5N+1 cycles after the start cycle.
- PC arithmetic is modulo 2^PC_WIDTH. The prog_len bound always terminates the run first, so PC never wraps during a run. prog_len=255 runs PCs 0..254.
- start in the same cycle as DONE is ignored. start is accepted only in IDLE.
- fpu_ack outside EXEC is ignored.

Test Plan:
- Two instructions, prog_len=2, FPU acks immediately. Instr0 = {13'd0, 3'b000} with A=1.5, B=2.25; instr1 = {13'd1, 3'b010} with A=3.0, B=-2.0 -> res[0]=3.75, res[1]=-6.0. done exactly 11 cycles after start; busy high for 10 cycles.
- FPU ack delayed 3 cycles on a DIV of 10.0/4.0 -> fpu_req high for 4 cycles with fpu_a/b stable throughout; result 2.5; single res_wr_en pulse.
- HALT bit set on instr1 of prog_len=4 -> exactly 2 writes (addresses 0 and 1), then done.
- fpu_ack never asserted, FPU_TIMEOUT=64 -> fpu_req high 64 cycles, then err_timeout=1, done pulse, no write. Next start clears err_timeout.
- prog_len=0 -> done 1 cycle after start, no imem/dmem/fpu activity. A start pulse while busy is ignored (one run only).
- reset asserted during EXEC -> fpu_req, busy and res_wr_en are 0 immediately (asynchronously). After release, a new start runs from PC=0.

Source files
------------

// File: rtl/fpu_program_sequencer.sv
// Program sequencer: fetches instructions, reads operand pairs, drives the FPU
// over a req/ack handshake and writes each result back by PC index.
module fpu_program_sequencer #(
    parameter int PC_WIDTH    = 8,
    parameter int ADDR_WIDTH  = 13,
    parameter int DATA_WIDTH  = 64,
    parameter int FPU_TIMEOUT = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [PC_WIDTH-1:0]     prog_len,
    output logic [PC_WIDTH-1:0]     imem_addr,
    input  logic [15:0]             imem_instr,
    output logic [ADDR_WIDTH-1:0]   dmem_addr,
    output logic                    dmem_rd_en,
    input  logic [2*DATA_WIDTH-1:0] dmem_data,
    output logic [DATA_WIDTH-1:0]   fpu_a,
    output logic [DATA_WIDTH-1:0]   fpu_b,
    output logic [1:0]              fpu_op,
    output logic                    fpu_req,
    input  logic                    fpu_ack,
    input  logic [DATA_WIDTH-1:0]   fpu_result,
    output logic                    res_wr_en,
    output logic [PC_WIDTH-1:0]     res_wr_addr,
    output logic [DATA_WIDTH-1:0]   res_wr_data,
    output logic                    busy,
    output logic                    done,
    output logic                    err_timeout
);

    localparam int CNT_W = $clog2(FPU_TIMEOUT + 1);
    localparam logic [CNT_W-1:0]    CNT_ONE = 1;
    localparam logic [CNT_W-1:0]    CNT_MAX = CNT_W'(FPU_TIMEOUT);
    localparam logic [PC_WIDTH-1:0] PC_ONE  = 1;
    localparam logic [PC_WIDTH-1:0] PC_ZERO = '0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_READ,
        S_WAIT_DATA,
        S_EXEC,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [PC_WIDTH-1:0]     r_pc;
    logic [PC_WIDTH-1:0]     r_len;
    logic [15:0]             r_instr;
    logic [DATA_WIDTH-1:0]   r_fpu_a;
    logic [DATA_WIDTH-1:0]   r_fpu_b;
    logic [1:0]              r_fpu_op;
    logic [DATA_WIDTH-1:0]   r_result;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_err;
    logic                    w_last;
    logic                    w_timeout;

    // The instruction is the last one if it carries HALT or hits the prog_len bound
    assign w_last    = r_instr[2] || (r_pc == (r_len - PC_ONE));
    assign w_timeout = (r_cnt == CNT_MAX);

    assign imem_addr   = r_pc;
    assign fpu_a       = r_fpu_a;
    assign fpu_b       = r_fpu_b;
    assign fpu_op      = r_fpu_op;
    assign err_timeout = r_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        fpu_req     = 1'b0;
        dmem_rd_en  = 1'b0;
        dmem_addr   = '0;
        res_wr_en   = 1'b0;
        res_wr_addr = '0;
        res_wr_data = '0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = (prog_len == PC_ZERO) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                busy   = 1'b1;
                w_next = S_READ;
            end
            S_READ: begin
                busy       = 1'b1;
                dmem_rd_en = 1'b1;
                dmem_addr  = r_instr[3 +: ADDR_WIDTH];
                w_next     = S_WAIT_DATA;
            end
            S_WAIT_DATA: begin
                busy   = 1'b1;
                w_next = S_EXEC;
            end
            S_EXEC: begin
                busy    = 1'b1;
                fpu_req = 1'b1;
                if (fpu_ack) begin
                    w_next = S_WRITE;
                end else if (w_timeout) begin
                    w_next = S_DONE;
                end
            end
            S_WRITE: begin
                busy        = 1'b1;
                res_wr_en   = 1'b1;
                res_wr_addr = r_pc;
                res_wr_data = r_result;
                w_next      = w_last ? S_DONE : S_FETCH;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc     <= '0;
            r_len    <= '0;
            r_instr  <= '0;
            r_fpu_a  <= '0;
            r_fpu_b  <= '0;
            r_fpu_op <= '0;
            r_result <= '0;
            r_cnt    <= '0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_len <= prog_len;
                        r_pc  <= '0;
                        r_err <= 1'b0;
                    end
                end
                S_FETCH: begin
                    r_instr <= imem_instr;
                end
                S_WAIT_DATA: begin
                    r_fpu_a  <= dmem_data[2*DATA_WIDTH-1:DATA_WIDTH];
                    r_fpu_b  <= dmem_data[DATA_WIDTH-1:0];
                    r_fpu_op <= r_instr[1:0];
                    r_cnt    <= CNT_ONE;
                end
                // r_cnt counts EXEC cycles, 1 on the first one
                S_EXEC: begin
                    if (fpu_ack) begin
                        r_result <= fpu_result;
                    end else if (w_timeout) begin
                        r_err <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                S_WRITE: begin
                    if (!w_last) begin
                        r_pc <= r_pc + PC_ONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
